// File: rtl/arty_io_pkg.sv
// Shared types and default constants for the board pin debounce logic.
package arty_io_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } deb_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 100000;
  localparam int SYNC_STAGES_DEF     = 2;

  // Value a pulled-up line rests at when nothing drives it.
  function automatic logic idle_level(input int active_low);
    return (active_low != 0) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/pin_debounce_ch.sv
// One pin channel: synchronizer, polarity fix, debounce FSM with counter,
// edge pulses and a sticky change flag.
module pin_debounce_ch
  import arty_io_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic evt_clr,
  output logic level,
  output logic assert_pulse,
  output logic deassert_pulse,
  output logic evt,
  output logic state
);

  localparam logic          IDLE = idle_level(ACTIVE_LOW);
  localparam int            CW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic                   accept;
  deb_state_t             state_q;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   assert_q;
  logic                   deassert_q;
  logic                   evt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IDLE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  assign sample = (ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

  // The change is accepted on the edge that sees the last required differing sample.
  always_comb begin
    accept = 1'b0;
    if ((state_q == ST_CHANGING) && (sample != level_q) && (cnt_q == LAST)) begin
      accept = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STABLE;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      assert_q   <= 1'b0;
      deassert_q <= 1'b0;
    end else begin
      assert_q   <= 1'b0;
      deassert_q <= 1'b0;
      case (state_q)
        ST_STABLE: begin
          if (sample != level_q) begin
            state_q <= ST_CHANGING;
            cnt_q   <= CW'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        ST_CHANGING: begin
          if (sample == level_q) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end else if (accept) begin
            state_q    <= ST_STABLE;
            cnt_q      <= '0;
            level_q    <= ~level_q;
            assert_q   <= ~level_q;
            deassert_q <= level_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Set beats clear so a change landing on a clear cycle is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q <= 1'b0;
    end else if (accept) begin
      evt_q <= 1'b1;
    end else if (evt_clr) begin
      evt_q <= 1'b0;
    end
  end

  assign level          = level_q;
  assign assert_pulse   = assert_q;
  assign deassert_pulse = deassert_q;
  assign evt            = evt_q;
  assign state          = (state_q == ST_CHANGING);

endmodule

// File: rtl/pin_debounce.sv
// Multi-channel pin debouncer: NUM_CH independent copies of the channel logic.
// dbg_state_o shows, per channel, whether a change is being qualified.
module pin_debounce
  import arty_io_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] pin_i,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] assert_o,
  output logic [NUM_CH-1:0] deassert_o,
  output logic [NUM_CH-1:0] evt_o,
  input  logic [NUM_CH-1:0] evt_clr_i,
  output logic [NUM_CH-1:0] dbg_state_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pin_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk           (clk_i),
      .rst           (rst_i),
      .pin           (pin_i[g]),
      .evt_clr       (evt_clr_i[g]),
      .level         (level_o[g]),
      .assert_pulse  (assert_o[g]),
      .deassert_pulse(deassert_o[g]),
      .evt           (evt_o[g]),
      .state         (dbg_state_o[g])
    );
  end

endmodule

// File: tb/tb_pin_debounce.sv
// Bench for pin_debounce: directed scenarios plus random pin traffic, all
// checked each cycle against a run-length reference model.
module tb_pin_debounce;

  localparam int NCH  = 2;
  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int LAT  = SYNC + DEB;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] pin = '1;
  logic [NCH-1:0] clr = '0;
  logic [NCH-1:0] level, as_p, de_p, evt, dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: SYNC-deep delay line, then a run length of samples that
  // disagree with the accepted level; DEB in a row flips the level.
  logic [SYNC-1:0] m_sync [NCH];
  int              m_run  [NCH];
  logic [NCH-1:0]  m_lvl, m_as, m_de, m_evt;

  pin_debounce #(
    .NUM_CH(NCH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pin_i(pin), .level_o(level), .assert_o(as_p),
    .deassert_o(de_p), .evt_o(evt), .evt_clr_i(clr), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_update();
    logic s;
    logic acc;
    for (int ch = 0; ch < NCH; ch++) begin
      if (rst) begin
        m_sync[ch] = '1;
        m_run[ch]  = 0;
        m_lvl[ch]  = 1'b0;
        m_as[ch]   = 1'b0;
        m_de[ch]   = 1'b0;
        m_evt[ch]  = 1'b0;
      end else begin
        s          = ~m_sync[ch][SYNC-1];
        m_sync[ch] = {m_sync[ch][SYNC-2:0], pin[ch]};
        m_as[ch]   = 1'b0;
        m_de[ch]   = 1'b0;
        acc        = 1'b0;
        if (s != m_lvl[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DEB) begin
            m_lvl[ch] = ~m_lvl[ch];
            m_as[ch]  = m_lvl[ch];
            m_de[ch]  = ~m_lvl[ch];
            m_run[ch] = 0;
            acc       = 1'b1;
          end
        end else begin
          m_run[ch] = 0;
        end
        if (acc) m_evt[ch] = 1'b1;
        else if (clr[ch]) m_evt[ch] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0] m_state;
    for (int ch = 0; ch < NCH; ch++) m_state[ch] = (m_run[ch] != 0);
    check("level",    32'(level),     32'(m_lvl));
    check("assert",   32'(as_p),      32'(m_as));
    check("deassert", 32'(de_p),      32'(m_de));
    check("evt",      32'(evt),       32'(m_evt));
    check("state",    32'(dbg_state), 32'(m_state));
    check("excl",     32'(as_p & de_p), 32'd0);
  endtask

  // Called at a falling edge: apply inputs, advance one cycle, check outputs.
  task automatic tick(input logic [NCH-1:0] p, input logic [NCH-1:0] c, input logic r);
    pin = p;
    clr = c;
    rst = r;
    @(posedge clk);
    cyc++;
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  // Hold inputs until level[ch] reaches want (bounded); report delay and pulses.
  task automatic wait_level(input int ch, input logic want, input logic [NCH-1:0] p,
                            input logic [NCH-1:0] c, output int delta,
                            output int n_as, output int n_de);
    int start;
    start = cyc;
    delta = -1;
    n_as  = 0;
    n_de  = 0;
    for (int i = 0; i < 4 * LAT; i++) begin
      tick(p, c, 1'b0);
      n_as += int'(as_p[ch]);
      n_de += int'(de_p[ch]);
      if (level[ch] == want) begin
        delta = cyc - start;
        break;
      end
    end
  endtask

  task automatic hold(input int n, input int ch, input logic [NCH-1:0] p,
                      inout int n_as, inout int n_de);
    for (int i = 0; i < n; i++) begin
      tick(p, '0, 1'b0);
      n_as += int'(as_p[ch]);
      n_de += int'(de_p[ch]);
    end
  endtask

  initial begin
    int d, d1, na, nd, na1, nd1, seen;
    logic [NCH-1:0] rp;
    int hold_cnt [NCH];

    for (int ch = 0; ch < NCH; ch++) begin
      m_sync[ch] = '1;
      m_run[ch]  = 0;
    end
    m_lvl = '0; m_as = '0; m_de = '0; m_evt = '0;

    @(negedge clk);
    tick('1, '0, 1'b1);
    tick('1, '0, 1'b1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_evt",   32'(evt),   32'd0);
    check("rst_pulse", 32'(as_p | de_p), 32'd0);
    tick('1, '0, 1'b0);

    // Bounce on channel 0: 3-cycle runs never reach the threshold.
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick({1'b1, ((i / 3) % 2 == 0) ? 1'b0 : 1'b1}, '0, 1'b0);
      seen += int'(level[0] | as_p[0] | evt[0]);
    end
    for (int i = 0; i < LAT + 2; i++) begin
      tick('1, '0, 1'b0);
      seen += int'(level[0] | as_p[0] | evt[0]);
    end
    check("bounce_quiet", 32'(seen), 32'd0);

    // Clean press on channel 0.
    wait_level(0, 1'b1, 2'b10, '0, d, na, nd);
    check("press_latency", 32'(d), 32'(LAT));
    hold(5, 0, 2'b10, na, nd);
    check("press_assert_cnt", 32'(na), 32'd1);
    check("press_evt", 32'(evt[0]), 32'd1);

    // Release on channel 0.
    wait_level(0, 1'b0, 2'b11, '0, d, na, nd);
    check("release_latency", 32'(d), 32'(LAT));
    hold(5, 0, 2'b11, na, nd);
    check("release_deassert_cnt", 32'(nd), 32'd1);
    check("release_assert_cnt", 32'(na), 32'd0);

    // Clear held on channel 1 across its accept cycle: set wins.
    wait_level(1, 1'b1, 2'b01, 2'b10, d, na, nd);
    check("coll_latency", 32'(d), 32'(LAT));
    check("coll_evt_set", 32'(evt[1]), 32'd1);
    tick(2'b01, '0, 1'b0);
    check("coll_evt_hold", 32'(evt[1]), 32'd1);
    tick(2'b01, 2'b10, 1'b0);
    check("coll_evt_clr", 32'(evt[1]), 32'd0);

    // Reset in the middle of a count on channel 0.
    tick(2'b11, '0, 1'b0);
    na = 0; nd = 0;
    hold(5, 0, 2'b00, na, nd);
    check("midrst_no_pulse", 32'(na + nd), 32'd0);
    tick(2'b00, '0, 1'b1);
    check("midrst_level", 32'(level), 32'd0);
    wait_level(0, 1'b1, 2'b00, '0, d, na, nd);
    check("midrst_latency", 32'(d), 32'(LAT));
    check("midrst_assert_cnt", 32'(na), 32'd1);

    // Independence: simultaneous steps, then channel 1 bounces.
    wait_level(0, 1'b0, 2'b11, '0, d, na, nd);
    wait_level(1, 1'b0, 2'b11, '0, d, na, nd);
    hold(4, 0, 2'b11, na, nd);
    fork
      begin end
    join
    d = -1; d1 = -1;
    for (int i = 0; i < 4 * LAT; i++) begin
      tick(2'b00, '0, 1'b0);
      if (level[0] && d < 0) d = i + 1;
      if (level[1] && d1 < 0) d1 = i + 1;
    end
    check("indep_lat0", 32'(d), 32'(LAT));
    check("indep_same_cycle", 32'(d1), 32'(d));
    na1 = 0; nd1 = 0;
    for (int i = 0; i < 30; i++) begin
      tick({((i / 2) % 2 == 0) ? 1'b1 : 1'b0, 1'b0}, '0, 1'b0);
      na1 += int'(as_p[0]);
      nd1 += int'(de_p[0]);
    end
    check("indep_ch0_level", 32'(level[0]), 32'd1);
    check("indep_ch0_pulses", 32'(na1 + nd1), 32'd0);

    // Random traffic: mixes short bounces with long holds, sparse clears and resets.
    rp = pin;
    for (int ch = 0; ch < NCH; ch++) hold_cnt[ch] = 0;
    for (int i = 0; i < 1500; i++) begin
      logic [NCH-1:0] rc;
      for (int ch = 0; ch < NCH; ch++) begin
        if (hold_cnt[ch] == 0) begin
          rp[ch] = ~rp[ch];
          hold_cnt[ch] = ($urandom_range(0, 2) == 0) ? $urandom_range(DEB + 1, 3 * DEB)
                                                      : $urandom_range(1, DEB - 1);
        end
        hold_cnt[ch]--;
        rc[ch] = ($urandom_range(0, 7) == 0);
      end
      tick(rp, rc, ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
